// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// Each operation runs IDLE -> EXEC -> DONE; operands are latched so requesters may change inputs mid-flight.
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    input  logic        sel0,
    input  logic        sel1,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_sel,
    input  logic [31:0] alu_result,
    output logic        grant0,
    output logic        grant1,
    output logic [31:0] result,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic        busy,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] op_a_r;
    logic [31:0] op_b_r;
    logic        op_sel_r;
    logic        owner_r;
    logic        last_grant_r;
    logic        grant0_r;
    logic        grant1_r;
    logic        rvalid0_r;
    logic        rvalid1_r;
    logic        busy_r;
    logic [31:0] result_r;
    logic [15:0] op_count_r;
    logic        pick_s;

    // Arbitration: a lone requester wins, a tie goes to whoever was not granted last.
    always_comb begin
        pick_s = 1'b0;
        if (req0 && req1) begin
            pick_s = ~last_grant_r;
        end else if (req1) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
    end

    // Operation sequencer with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            op_a_r       <= 32'd0;
            op_b_r       <= 32'd0;
            op_sel_r     <= 1'b0;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            grant0_r     <= 1'b0;
            grant1_r     <= 1'b0;
            rvalid0_r    <= 1'b0;
            rvalid1_r    <= 1'b0;
            busy_r       <= 1'b0;
            result_r     <= 32'd0;
            op_count_r   <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req0 || req1) begin
                        owner_r      <= pick_s;
                        last_grant_r <= pick_s;
                        op_a_r       <= pick_s ? a1 : a0;
                        op_b_r       <= pick_s ? b1 : b0;
                        op_sel_r     <= pick_s ? sel1 : sel0;
                        grant0_r     <= ~pick_s;
                        grant1_r     <= pick_s;
                        busy_r       <= 1'b1;
                        state_r      <= EXEC;
                    end else begin
                        state_r      <= IDLE;
                    end
                end
                EXEC: begin
                    result_r   <= alu_result;
                    op_count_r <= op_count_r + 16'd1;
                    rvalid0_r  <= ~owner_r;
                    rvalid1_r  <= owner_r;
                    state_r    <= DONE;
                end
                DONE: begin
                    rvalid0_r <= 1'b0;
                    rvalid1_r <= 1'b0;
                    grant0_r  <= 1'b0;
                    grant1_r  <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    rvalid0_r <= 1'b0;
                    rvalid1_r <= 1'b0;
                    grant0_r  <= 1'b0;
                    grant1_r  <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign alu_a    = op_a_r;
    assign alu_b    = op_b_r;
    assign alu_sel  = op_sel_r;
    assign grant0   = grant0_r;
    assign grant1   = grant1_r;
    assign rvalid0  = rvalid0_r;
    assign rvalid1  = rvalid1_r;
    assign busy     = busy_r;
    assign result   = result_r;
    assign op_count = op_count_r;

endmodule
